// File: rtl/qspi_psram_responder_pkg.sv
// Shared opcodes and FSM state encoding for the QSPI PSRAM responder.
// Imported by the responder top and its bench.
package kianv_psram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_FREAD  = 8'h0B;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    localparam logic [3:0] FREAD_DUMMY = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_e;

endpackage

// File: rtl/qspi_psram_responder_if.sv
// Pin bundle between a QSPI memory initiator and the PSRAM responder.
// master = initiator side, slave = responder side.
interface qspi_psram_if;

    logic       ce_n;
    logic       sclk;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic [3:0] sio_oe;
    logic       busy;

    modport master (
        output ce_n,
        output sclk,
        output sio_i,
        input  sio_o,
        input  sio_oe,
        input  busy
    );

    modport slave (
        input  ce_n,
        input  sclk,
        input  sio_i,
        output sio_o,
        output sio_oe,
        output busy
    );

endinterface

// File: rtl/qspi_psram_responder_sync.sv
// Two-flop synchronisers for the asynchronous SPI pins plus edge pulses.
// Left without reset so a reset mid-transfer cannot fake a ce_n fall.
module spi_pin_sync (
    input  logic       clk,
    input  logic       ce_n_i,
    input  logic       sclk_i,
    input  logic [3:0] sio_i,
    output logic       ce_n_o,
    output logic [3:0] sio_o,
    output logic       sclk_rise_o,
    output logic       sclk_fall_o,
    output logic       ce_fall_o,
    output logic       ce_rise_o
);

    logic [2:0] ce_q;
    logic [2:0] sclk_q;
    logic [3:0] sio0_q;
    logic [3:0] sio1_q;

    always_ff @(posedge clk) begin
        ce_q   <= {ce_q[1:0], ce_n_i};
        sclk_q <= {sclk_q[1:0], sclk_i};
        sio0_q <= sio_i;
        sio1_q <= sio0_q;
    end

    // Data taps stage 2, aligned with the sclk level used for edges
    assign ce_n_o      = ce_q[1];
    assign sio_o       = sio1_q;
    assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
    assign ce_fall_o   = ~ce_q[1] & ce_q[2];
    assign ce_rise_o   = ce_q[1] & ~ce_q[2];

endmodule

// File: rtl/qspi_psram_responder.sv
// PSRAM-style QSPI target oversampling SPI mode 0 on clk; byte array backing store.
// Quad commands 0xEB/0x38 are built only when KIANV_PSRAM_QUAD_EN is defined.
module qspi_psram_responder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int QDUMMY = 6
) (
    input logic          clk,
    input logic          rst,
    qspi_psram_if.slave  bus
);

    import kianv_psram_pkg::*;

    logic        ce_s;
    logic [3:0]  sio_s;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        ce_fall;
    logic        ce_rise;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic [3:0]  dum_q, dum_d;
    logic [3:0]  sio_o_q, sio_o_d;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  rd_byte;
    logic [7:0]  rd_src;
    logic [7:0]  cmd_byte;
    logic [7:0]  wr_byte;
    logic        mem_we;
    logic [7:0]  mem_wdata;

    logic [4:0]  addr_last;
    logic [4:0]  byte_last;
    logic [3:0]  oe_mode;

    spi_pin_sync u_sync (
        .clk         (clk),
        .ce_n_i      (bus.ce_n),
        .sclk_i      (bus.sclk),
        .sio_i       (bus.sio_i),
        .ce_n_o      (ce_s),
        .sio_o       (sio_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ce_fall_o   (ce_fall),
        .ce_rise_o   (ce_rise)
    );

`ifdef KIANV_PSRAM_QUAD_EN
    logic quad_q, quad_d;

    assign addr_last = quad_q ? 5'd5 : 5'd23;
    assign byte_last = quad_q ? 5'd1 : 5'd7;
    assign oe_mode   = quad_q ? 4'b1111 : 4'b0010;
    assign wr_byte   = quad_q ? {sh_q[3:0], sio_s}
                              : {sh_q[6:0], sio_s[0]};
`else
    logic unused_pins;

    assign addr_last   = 5'd23;
    assign byte_last   = 5'd7;
    assign oe_mode     = 4'b0010;
    assign wr_byte     = {sh_q[6:0], sio_s[0]};
    assign unused_pins = ^{sio_s[3:1], 4'(QDUMMY)};
`endif

    assign rd_byte  = mem[addr_q];
    assign cmd_byte = {sh_q[6:0], sio_s[0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        dum_d     = dum_q;
        sio_o_d   = sio_o_q;
        rd_src    = sh_q;
        mem_we    = 1'b0;
        mem_wdata = wr_byte;
`ifdef KIANV_PSRAM_QUAD_EN
        quad_d    = quad_q;
`endif
        if (state_q != IDLE && (ce_s || ce_rise)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ce_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        sh_d  = cmd_byte;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = '0;
                            state_d = ADDR;
                            rd_d    = 1'b1;
                            dum_d   = 4'd0;
`ifdef KIANV_PSRAM_QUAD_EN
                            quad_d  = 1'b0;
`endif
                            case (cmd_byte)
                                CMD_READ:   ;
                                CMD_FREAD:  dum_d = FREAD_DUMMY;
                                CMD_WRITE:  rd_d  = 1'b0;
`ifdef KIANV_PSRAM_QUAD_EN
                                CMD_QREAD: begin
                                    quad_d = 1'b1;
                                    dum_d  = 4'(QDUMMY);
                                end
                                CMD_QWRITE: begin
                                    quad_d = 1'b1;
                                    rd_d   = 1'b0;
                                end
`endif
                                default:    state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        cnt_d  = cnt_q + 5'd1;
                        addr_d = {addr_q[ADDR_W-2:0], sio_s[0]};
`ifdef KIANV_PSRAM_QUAD_EN
                        if (quad_q)
                            addr_d = {addr_q[ADDR_W-5:0], sio_s};
`endif
                        if (cnt_q == addr_last) begin
                            cnt_d = '0;
                            if (!rd_q)
                                state_d = WDATA;
                            else if (dum_q == 4'd0)
                                state_d = RDATA;
                            else
                                state_d = DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == {1'b0, dum_q - 4'd1}) begin
                            cnt_d   = '0;
                            state_d = RDATA;
                        end
                    end
                end
                RDATA: begin
                    // Fetch on the first fall of each byte, then shift
                    if (sclk_fall) begin
                        rd_src  = (cnt_q == 5'd0) ? rd_byte : sh_q;
                        sio_o_d = {2'b00, rd_src[7], 1'b0};
                        sh_d    = {rd_src[6:0], 1'b0};
`ifdef KIANV_PSRAM_QUAD_EN
                        if (quad_q) begin
                            sio_o_d = rd_src[7:4];
                            sh_d    = {rd_src[3:0], 4'h0};
                        end
`endif
                        if (cnt_q == byte_last) begin
                            cnt_d  = '0;
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        sh_d = wr_byte;
                        if (cnt_q == byte_last) begin
                            cnt_d  = '0;
                            mem_we = 1'b1;
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            dum_q   <= '0;
            sio_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            dum_q   <= dum_d;
            sio_o_q <= sio_o_d;
        end
    end

`ifdef KIANV_PSRAM_QUAD_EN
    always_ff @(posedge clk) begin
        if (rst)
            quad_q <= 1'b0;
        else
            quad_q <= quad_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[addr_q] <= mem_wdata;
    end

    assign bus.sio_o  = sio_o_q;
    assign bus.sio_oe = (state_q == RDATA && !ce_s) ? oe_mode : 4'h0;
    assign bus.busy   = !ce_s && (state_q == ADDR  || state_q == DUMMY ||
                                  state_q == RDATA || state_q == WDATA);

endmodule
